// File: rtl/debug_ctrl.sv
// UART-driven debug controller: single-step, free-run, snapshot dump and reset of a datapath.
// All outputs are registered; each one is computed from the next state so it lines up with state_q.
module debug_ctrl #(
  parameter int          DUMP_BYTES = 3,
  parameter logic [7:0]  CMD_STEP   = 8'h70,
  parameter logic [7:0]  CMD_CONT   = 8'h63,
  parameter logic [7:0]  CMD_DUMP   = 8'h64,
  parameter logic [7:0]  CMD_STOP   = 8'h73,
  parameter logic [7:0]  CMD_RST    = 8'h72,
  parameter int          RST_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_bus,
  input  logic                    tx_done,
  input  logic [DUMP_BYTES*8-1:0] dp_bus,
  input  logic                    dp_halt,
  output logic                    dp_clk,
  output logic                    dp_reset,
  output logic                    tx_write,
  output logic [7:0]              tx_bus,
  output logic                    busy
);

  localparam int IW = (DUMP_BYTES > 1) ? $clog2(DUMP_BYTES) : 1;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DUMP_BYTES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, STEP_HI, STEP_LO, RUN, SNAP, TX_LOAD, TX_WAIT, HALTED, DP_RST
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           rst_cnt_q, rst_cnt_d;
  logic                    halt_q, halt_d;
  logic [DUMP_BYTES*8-1:0] shadow_q, shadow_d;
  logic                    dp_clk_q, dp_clk_d;
  logic                    dp_reset_q, dp_reset_d;
  logic                    tx_write_q, tx_write_d;
  logic [7:0]              tx_bus_q, tx_bus_d;
  logic                    busy_q, busy_d;
  logic                    run_exit;

  assign run_exit = dp_halt || (rx_rdy && (rx_bus == CMD_STOP));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_cnt_d = rst_cnt_q;
    halt_d    = halt_q;
    shadow_d  = shadow_q;
    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          if (rx_bus == CMD_STEP)      state_d = STEP_HI;
          else if (rx_bus == CMD_CONT) state_d = RUN;
          else if (rx_bus == CMD_DUMP) state_d = SNAP;
          else if (rx_bus == CMD_RST) begin
            state_d   = DP_RST;
            rst_cnt_d = '0;
          end
        end
      end
      STEP_HI: state_d = STEP_LO;
      STEP_LO: state_d = SNAP;
      // Leaving during a high phase reuses STEP_LO for the closing low phase.
      RUN: if (run_exit) state_d = dp_clk_q ? STEP_LO : SNAP;
      SNAP: begin
        shadow_d = dp_bus;
        idx_d    = '0;
        halt_d   = dp_halt;
        state_d  = TX_LOAD;
      end
      TX_LOAD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = halt_q ? HALTED : IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = TX_LOAD;
          end
        end
      end
      HALTED: begin
        if (rx_rdy) begin
          if (rx_bus == CMD_DUMP) state_d = SNAP;
          else if (rx_bus == CMD_RST) begin
            state_d   = DP_RST;
            rst_cnt_d = '0;
          end
        end
      end
      DP_RST: begin
        halt_d = 1'b0;
        if (rst_cnt_q == RST_LAST) state_d = IDLE;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    dp_clk_d   = (state_d == STEP_HI) ||
                 ((state_d == RUN) && ((state_q != RUN) || !dp_clk_q));
    dp_reset_d = (state_d == DP_RST);
    tx_write_d = (state_d == TX_LOAD);
    tx_bus_d   = tx_write_d ? 8'(shadow_d >> {idx_d, 3'b000}) : tx_bus_q;
    busy_d     = (state_d != IDLE) && (state_d != HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rst_cnt_q  <= '0;
      halt_q     <= 1'b0;
      shadow_q   <= '0;
      dp_clk_q   <= 1'b0;
      dp_reset_q <= 1'b0;
      tx_write_q <= 1'b0;
      tx_bus_q   <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rst_cnt_q  <= rst_cnt_d;
      halt_q     <= halt_d;
      shadow_q   <= shadow_d;
      dp_clk_q   <= dp_clk_d;
      dp_reset_q <= dp_reset_d;
      tx_write_q <= tx_write_d;
      tx_bus_q   <= tx_bus_d;
      busy_q     <= busy_d;
    end
  end

  assign dp_clk   = dp_clk_q;
  assign dp_reset = dp_reset_q;
  assign tx_write = tx_write_q;
  assign tx_bus   = tx_bus_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed bench for debug_ctrl: a 3-byte instance for most scenarios, a 5-byte instance for dump isolation.
module tb_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_rdy = 1'b0, rx_rdy5 = 1'b0;
  logic [7:0]  rx_bus = 8'h00, rx_bus5 = 8'h00;
  logic        tx_done = 1'b0, tx_done5 = 1'b0;
  logic [23:0] dp_bus = 24'h0;
  logic [39:0] dp_bus5 = 40'h0;
  logic        dp_halt = 1'b0, dp_halt5 = 1'b0;
  logic        dp_clk, dp_reset, tx_write, busy;
  logic        dp_clk5, dp_reset5, tx_write5, busy5;
  logic [7:0]  tx_bus, tx_bus5;

  int checks = 0;
  int failures = 0;

  int q3[$];
  int q5[$];
  int rises3 = 0, rises5 = 0;
  logic prev3 = 1'b0, prev5 = 1'b0;
  int dly3 = 0, dly5 = 0;
  bit resp_en = 1'b1;

  always #5 clk = ~clk;

  debug_ctrl u3 (
    .clk(clk), .reset(reset), .rx_rdy(rx_rdy), .rx_bus(rx_bus), .tx_done(tx_done),
    .dp_bus(dp_bus), .dp_halt(dp_halt), .dp_clk(dp_clk), .dp_reset(dp_reset),
    .tx_write(tx_write), .tx_bus(tx_bus), .busy(busy)
  );

  debug_ctrl #(.DUMP_BYTES(5)) u5 (
    .clk(clk), .reset(reset), .rx_rdy(rx_rdy5), .rx_bus(rx_bus5), .tx_done(tx_done5),
    .dp_bus(dp_bus5), .dp_halt(dp_halt5), .dp_clk(dp_clk5), .dp_reset(dp_reset5),
    .tx_write(tx_write5), .tx_bus(tx_bus5), .busy(busy5)
  );

  // UART model: logs each written byte and answers with tx_done three cycles later.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (dp_clk && !prev3) rises3++;
    prev3 = dp_clk;
    if (tx_write) begin
      q3.push_back(int'(tx_bus));
      dly3 = 3;
    end else if (dly3 != 0) begin
      dly3--;
      if (dly3 == 0 && resp_en) tx_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    tx_done5 = 1'b0;
    if (dp_clk5 && !prev5) rises5++;
    prev5 = dp_clk5;
    if (tx_write5) begin
      q5.push_back(int'(tx_bus5));
      dly5 = 3;
    end else if (dly5 != 0) begin
      dly5--;
      if (dly5 == 0) tx_done5 = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send3(input logic [7:0] b);
    rx_rdy = 1'b1; rx_bus = b;
    step();
    rx_rdy = 1'b0; rx_bus = 8'h00;
  endtask

  task automatic send5(input logic [7:0] b);
    rx_rdy5 = 1'b1; rx_bus5 = b;
    step();
    rx_rdy5 = 1'b0; rx_bus5 = 8'h00;
  endtask

  task automatic wait_idle3(input string tag);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    check({tag, "_timeout"}, 64'(n < 300), 64'd1);
  endtask

  task automatic expect_bytes3(input string tag, input logic [23:0] val);
    check({tag, "_count"}, 64'(q3.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (q3.size() > 0) check({tag, "_byte"}, 64'(q3.pop_front()), 64'(val[i*8 +: 8]));
    end
  endtask

  initial begin
    int n;
    step(); step();
    check("rst_dp_clk", 64'(dp_clk), 64'd0);
    check("rst_dp_reset", 64'(dp_reset), 64'd0);
    check("rst_tx_write", 64'(tx_write), 64'd0);
    check("rst_tx_bus", 64'(tx_bus), 64'h00);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Single step, then dump of C0FFEE
    dp_bus = 24'hC0FFEE;
    q3.delete(); rises3 = 0;
    send3(8'h70);
    check("step_hi_clk", 64'(dp_clk), 64'd1);
    check("step_busy", 64'(busy), 64'd1);
    step();
    check("step_lo_clk", 64'(dp_clk), 64'd0);
    wait_idle3("step");
    check("step_rises", 64'(rises3), 64'd1);
    expect_bytes3("step", 24'hC0FFEE);
    check("step_idle_busy", 64'(busy), 64'd0);

    // Continuous run stopped by halt
    rises3 = 0;
    send3(8'h63);
    check("run_first_clk", 64'(dp_clk), 64'd1);
    step();
    check("run_toggle_clk", 64'(dp_clk), 64'd0);
    repeat (9) step();
    dp_halt = 1'b1; dp_bus = 24'h123456;
    wait_idle3("halt");
    expect_bytes3("halt", 24'h123456);
    check("halt_dp_clk", 64'(dp_clk), 64'd0);
    rises3 = 0;
    send3(8'h70);
    repeat (5) step();
    check("halt_p_busy", 64'(busy), 64'd0);
    check("halt_p_rises", 64'(rises3), 64'd0);
    check("halt_p_tx", 64'(q3.size()), 64'd0);

    // Datapath reset out of HALTED
    send3(8'h72);
    n = 0;
    while (dp_reset && n < 20) begin n++; step(); end
    check("dprst_len", 64'(n), 64'd4);
    check("dprst_busy", 64'(busy), 64'd0);
    dp_halt = 1'b0; dp_bus = 24'hA1B2C3;
    rises3 = 0;
    send3(8'h70);
    check("after_rst_busy", 64'(busy), 64'd1);
    wait_idle3("after_rst");
    check("after_rst_rises", 64'(rises3), 64'd1);
    expect_bytes3("after_rst", 24'hA1B2C3);

    // Continuous run stopped by command
    dp_bus = 24'h0BEEF1;
    send3(8'h63);
    repeat (5) step();
    send3(8'h73);
    wait_idle3("stop");
    check("stop_dp_clk", 64'(dp_clk), 64'd0);
    expect_bytes3("stop", 24'h0BEEF1);
    send3(8'h64);
    check("stop_then_idle", 64'(busy), 64'd1);
    wait_idle3("stop_dump");
    expect_bytes3("stop_dump", 24'h0BEEF1);

    // Five-byte dump ignores dp_bus changes after the snapshot
    dp_bus5 = 40'h1122334455;
    send5(8'h64);
    n = 0;
    while (q5.size() < 1 && n < 50) begin step(); n++; end
    dp_bus5 = 40'hAAAAAAAAAA;
    n = 0;
    while (busy5 && n < 300) begin step(); n++; end
    check("dump5_timeout", 64'(n < 300), 64'd1);
    check("dump5_count", 64'(q5.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (q5.size() > 0) check("dump5_byte", 64'(q5.pop_front()), 64'(5'd5 - 5'(i)) * 64'h11);
    check("dump5_rises", 64'(rises5), 64'd0);

    // Reset in the second TX_WAIT abandons the dump
    dp_bus = 24'hABCDEF;
    send3(8'h64);
    n = 0;
    while (q3.size() < 2 && n < 100) begin step(); n++; end
    step();
    check("mid_state_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    check("mid_rst_tx_write", 64'(tx_write), 64'd0);
    check("mid_rst_tx_bus", 64'(tx_bus), 64'h00);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dp_clk", 64'(dp_clk), 64'd0);
    reset = 1'b0;
    repeat (10) step();
    check("mid_rst_no_more_tx", 64'(q3.size()), 64'd2);
    q3.delete();
    rises3 = 0;
    send3(8'h41);
    check("unknown_busy", 64'(busy), 64'd0);
    repeat (5) step();
    check("unknown_quiet", 64'(q3.size() + rises3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
